// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed when the operation is accepted and committed to hi/lo once the latency counter expires.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     p_hi, p_lo;
    logic [2*WIDTH-1:0]   prod_s, prod_u, res;
    logic                 dz, ovf;
    logic [WIDTH-1:0]     sdb, udb, q_s, r_s, q_u, r_u;
    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign dz  = (B == '0);
    assign ovf = (A == MIN_NEG) && (B == '1);
    // Substitute a divisor of 1 for the special cases: this keeps simulation X-free
    // and makes the signed-overflow case yield quotient=A, remainder=0 directly.
    assign sdb = (dz || ovf) ? WIDTH'(1) : B;
    assign udb = dz ? WIDTH'(1) : B;
    assign q_s = $signed(A) / $signed(sdb);
    assign r_s = $signed(A) % $signed(sdb);
    assign q_u = A / udb;
    assign r_u = A % udb;
    always_comb begin
        res = (op == 3'd0) ? prod_s :
              (op == 3'd1) ? prod_u :
              dz           ? {A, {WIDTH{1'b1}}} :
              (op == 3'd2) ? {r_s, q_s} : {r_u, q_u};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                hi   <= p_hi;
                lo   <= p_lo;
            end
        end else if (start) begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    busy <= 1'b1;
                    cnt  <= op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
                    p_hi <= res[2*WIDTH-1:WIDTH];
                    p_lo <= res[WIDTH-1:0];
                end
                3'd4:    hi <= A;
                3'd5:    lo <= A;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the next-generation 5-stage pipeline. It sits in EX beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage. Holds the result for MEM/WB readout via mfhi/mflo.
- Drives `busy` so that the hazard logic can stall any md-class instruction in ID while an operation is in flight.
- Width and per-operation latency are parameters. Also provides a flush for cancelling an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_LAT, 5, cycles from `start` to HI/LO update for mult/multu; must be ≥1.
- DIV_LAT, 10, cycles from `start` to HI/LO update for div/divu; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX-stage md instruction valid this cycle.
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6 and 7 are reserved and do nothing.
- A  in  WIDTH  rs operand, already forwarded.
- B  in  WIDTH  rt operand, already forwarded.
- flush  in  1  cancel the in-flight mult/div; HI/LO are left unchanged.
- busy  out  1  high while a mult/div is in flight (registered).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset:
  - busy=0, hi=0, lo=0, counter=0, pending result cleared.
  - Reset overrides start and flush.
  - Reset during an in-flight operation aborts it; no late HI/LO write occurs.
- Accept rule: `start` is honoured only when busy=0 and flush=0. If busy=1, `start` is ignored, because hazard logic must already have stalled the instruction.
- mult/multu/div/divu accepted at edge N:
  - The full result is computed from A/B and latched into pending registers at edge N.
  - The counter loads LAT, and busy=1 from edge N onward.
  - The counter decrements each cycle.
  - At edge N+LAT, hi/lo take the pending result and busy=0.
  - busy is therefore high for exactly LAT cycles.
  - A back-to-back start is legal in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 2·WIDTH product, hi=upper half, lo=lower half.
  - multu: unsigned 2·WIDTH product, hi=upper half, lo=lower half.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero (B=0): lo = all ones, hi = A, for both div and divu. No trap is raised.
- Signed overflow (div, A=most-negative, B=−1): lo=A, hi=0.
- mthi/mtlo with busy=0:
  - hi (or lo) := A at the same edge; busy stays 0.
  - The other register is unchanged.
- mthi/mtlo with busy=1: ignored like any other start.
- flush=1:
  - At the next edge busy=0, the counter clears and the pending result is discarded.
  - hi/lo keep their pre-operation values.
  - flush and start in the same cycle: flush wins and the start is dropped.
- Completion edge coinciding with flush: flush wins and the result is discarded.
- hi/lo are direct register outputs. mfhi/mflo see the new value in the cycle after the update edge, so there is no forward from the pending registers.
- Stall contract for the pipeline: stall ID when (busy | start) and the ID instruction is md-class (mult/div/mthi/mtlo/mfhi/mflo). The unit only provides busy; the hazard logic combines the terms.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (−2), B=3 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1.
- Corner divides:
  - div A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu A=5, B=0 → lo=0xFFFFFFFF, hi=5.
- Start div, pulse start with op=mthi while busy=1 → mthi ignored, final hi=remainder. After busy falls, mthi A=0x1234 → hi=0x1234 next cycle, busy stays 0, lo unchanged.
- Preload hi=0xAA/lo=0xBB via mthi/mtlo, start mult, assert flush in cycle 3 → busy=0 next cycle, hi=0xAA, lo=0xBB held. Repeat with flush on the completion cycle → same result.
- Start div, assert reset in cycle 4 → next cycle busy=0, hi=lo=0, and no update appears at cycle 10. Also rerun with MULT_LAT=1, DIV_LAT=1, WIDTH=16 → single-cycle busy, 16-bit results correct.
